// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between two req/gnt requesters.
// Define MEM_ARB_PERF_EN to add per-requester saturating stall counters.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WIDTH-1:0]      m0_wdata_i,
  input  logic [WIDTH/8-1:0]    m0_be_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [WIDTH-1:0]      m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WIDTH-1:0]      m1_wdata_i,
  input  logic [WIDTH/8-1:0]    m1_be_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [WIDTH-1:0]      m1_rdata_o,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]           m0_stall_cnt_o,
  output logic [31:0]           m1_stall_cnt_o,
`endif
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic [WIDTH/8-1:0]    mem_be_o,
  input  logic [WIDTH-1:0]      mem_rdata_i
);
  logic last_q, last_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_id_q, rsp_id_d;
  logic rsp_we_q, rsp_we_d;
  // last_q names the previous winner; the other requester wins a conflict
  always_comb begin
    m0_gnt_o    = rst_ni & m0_req_i & (~m1_req_i | last_q);
    m1_gnt_o    = rst_ni & m1_req_i & (~m0_req_i | ~last_q);
    mem_en_o    = m0_gnt_o | m1_gnt_o;
    mem_we_o    = m0_gnt_o ? m0_we_i    : m1_gnt_o ? m1_we_i    : 1'b0;
    mem_addr_o  = m0_gnt_o ? m0_addr_i  : m1_gnt_o ? m1_addr_i  : '0;
    mem_wdata_o = m0_gnt_o ? m0_wdata_i : m1_gnt_o ? m1_wdata_i : '0;
    mem_be_o    = m0_gnt_o ? m0_be_i    : m1_gnt_o ? m1_be_i    : '0;
    last_d      = m0_gnt_o ? 1'b0 : m1_gnt_o ? 1'b1 : last_q;
    rsp_valid_d = mem_en_o;
    rsp_id_d    = m1_gnt_o;
    rsp_we_d    = mem_we_o;
    m0_rvalid_o = rsp_valid_q & ~rsp_id_q;
    m1_rvalid_o = rsp_valid_q & rsp_id_q;
    m0_rdata_o  = (m0_rvalid_o & ~rsp_we_q) ? mem_rdata_i : '0;
    m1_rdata_o  = (m1_rvalid_o & ~rsp_we_q) ? mem_rdata_i : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_we_q    <= rsp_we_d;
    end
  end
`ifdef MEM_ARB_PERF_EN
  logic [31:0] stall0_q, stall0_d, stall1_q, stall1_d;
  always_comb begin
    stall0_d = (m0_req_i & ~m0_gnt_o & (stall0_q != '1)) ? stall0_q + 32'd1 : stall0_q;
    stall1_d = (m1_req_i & ~m1_gnt_o & (stall1_q != '1)) ? stall1_q + 32'd1 : stall1_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      stall0_q <= stall0_d;
      stall1_q <= stall1_d;
    end
  end
  assign m0_stall_cnt_o = stall0_q;
  assign m1_stall_cnt_o = stall1_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  logic clk = 0, rst_n = 0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [7:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [3:0] m0_be = 0, m1_be = 0;
  logic m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic mem_en_o, mem_we_o;
  logic [7:0] mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata;
  logic [3:0] mem_be_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] m0_stall_cnt_o, m1_stall_cnt_o;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
`ifdef MEM_ARB_PERF_EN
    .m0_stall_cnt_o(m0_stall_cnt_o), .m1_stall_cnt_o(m1_stall_cnt_o),
`endif
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata)
  );

  // memory macro stand-in, driven by the DUT's command port
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o && mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      mem_rdata <= mem[mem_addr_o];
    end
  end

  // reference model: one transaction per cycle, winner by round-robin over the last winner
  logic [31:0] ref_mem [256];
  logic m_last, m_rv, m_id;
  logic [31:0] m_data;
  logic e_any, e_win, e_g0, e_g1, e_rv0, e_rv1, w_we;
  logic [7:0] w_addr;
  logic [31:0] w_wdata, e_rd0, e_rd1;
  logic [3:0] w_be;
  logic [44:0] e_cmd;
  always_comb begin
    e_any   = rst_n & (m0_req | m1_req);
    e_win   = (m0_req & m1_req) ? ~m_last : m1_req;
    e_g0    = e_any & ~e_win;
    e_g1    = e_any & e_win;
    w_we    = e_win ? m1_we : m0_we;
    w_addr  = e_win ? m1_addr : m0_addr;
    w_wdata = e_win ? m1_wdata : m0_wdata;
    w_be    = e_win ? m1_be : m0_be;
    e_cmd   = e_any ? {w_we, w_addr, w_wdata, w_be} : '0;
    e_rv0   = m_rv & ~m_id;
    e_rv1   = m_rv & m_id;
    e_rd0   = e_rv0 ? m_data : 32'h0;
    e_rd1   = e_rv1 ? m_data : 32'h0;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= 1; m_rv <= 0; m_id <= 0; m_data <= 0;
    end else begin
      m_rv <= e_any;
      if (e_any) begin
        m_last <= e_win;
        m_id   <= e_win;
        m_data <= w_we ? 32'h0 : ref_mem[w_addr];
        for (int b = 0; b < 4; b++)
          if (w_we && w_be[b]) ref_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_m(input int n, input logic req, input logic we, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (n == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be; end
    else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be; end
  endtask

  task automatic do_reset();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_m(0, 1, 1, 8'h12, 32'hDEADBEEF, 4'hF);
    set_m(1, 1, 0, 8'h34, 32'hCAFEF00D, 4'h3);
    @(negedge clk);
    total++;
    if ({m0_gnt_o, m1_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
      bad++; $display("FAIL reset_gating: gnt=%b%b en=%b cmd=%h/%h/%h, need all 0",
                      m0_gnt_o, m1_gnt_o, mem_en_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    total++;
    if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== '0) begin
      bad++; $display("FAIL reset_rsp: rvalid=%b%b rdata=%h/%h, need 0", m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o);
    end
    do_reset();
    @(negedge clk);
    total++;
    if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, m0_rvalid_o, m1_rvalid_o} !== '0) begin
      bad++; $display("FAIL idle_outputs: en=%b be=%h rvalid=%b%b, need 0", mem_en_o, mem_be_o, m0_rvalid_o, m1_rvalid_o);
    end
    tick();
  endtask

  task automatic test_write_read();
    for (int i = 0; i <= 16; i++) begin
      set_m(0, i < 16, 1, 8'(i), 32'(i) * 32'h11111111, 4'hF);
      @(negedge clk);
      total++;
      if (m0_gnt_o !== (i < 16) || m1_gnt_o !== 1'b0 || (i < 16 && mem_addr_o !== 8'(i))) begin
        bad++; $display("FAIL wr_gnt[%0d]: gnt0=%b addr=%h, need gnt0=%b addr=%h", i, m0_gnt_o, mem_addr_o, i < 16, 8'(i));
      end
      total++;
      if (m0_rvalid_o !== (i > 0) || m0_rdata_o !== 32'h0) begin
        bad++; $display("FAIL wr_rsp[%0d]: rvalid=%b rdata=%h, need %b 0", i, m0_rvalid_o, m0_rdata_o, i > 0);
      end
      tick();
    end
    for (int i = 0; i <= 16; i++) begin
      set_m(0, i < 16, 0, 8'(i), 32'h0, 4'hF);
      @(negedge clk);
      total++;
      if (m0_gnt_o !== (i < 16)) begin
        bad++; $display("FAIL rd_gnt[%0d]: gnt0=%b need %b", i, m0_gnt_o, i < 16);
      end
      if (i > 0) begin
        total++;
        if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'(i - 1) * 32'h11111111 || m1_rvalid_o !== 1'b0) begin
          bad++; $display("FAIL rd_data[%0d]: rvalid=%b rdata=%h, need 1 %h", i - 1, m0_rvalid_o, m0_rdata_o,
                          32'(i - 1) * 32'h11111111);
        end
      end
      tick();
    end
  endtask

  task automatic test_alternate();
    do_reset();
    set_m(0, 1, 0, 8'd1, 0, 4'hF);
    set_m(1, 1, 0, 8'd2, 0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (m0_gnt_o !== (k % 2 == 0) || m1_gnt_o !== (k % 2 == 1)) begin
        bad++; $display("FAIL alt_gnt[%0d]: gnt=%b%b need %b%b", k, m0_gnt_o, m1_gnt_o, k % 2 == 0, k % 2 == 1);
      end
      if (k > 0) begin
        total++;
        if (m0_rvalid_o !== (k % 2 == 1) || m1_rvalid_o !== (k % 2 == 0) ||
            m0_rdata_o !== ((k % 2 == 1) ? 32'h11111111 : 32'h0) ||
            m1_rdata_o !== ((k % 2 == 0) ? 32'h22222222 : 32'h0)) begin
          bad++; $display("FAIL alt_rsp[%0d]: rvalid=%b%b rdata=%h/%h", k, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o);
        end
      end
      tick();
    end
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_byte_enable();
    set_m(1, 1, 1, 8'd3, 32'h00000000, 4'hF);
    tick();
    set_m(1, 1, 1, 8'd3, 32'hFFFFFFFF, 4'h1);
    @(negedge clk);
    total++;
    if (m1_gnt_o !== 1'b1 || mem_be_o !== 4'h1 || mem_wdata_o !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL be_cmd: gnt1=%b be=%h wdata=%h, need 1 1 ffffffff", m1_gnt_o, mem_be_o, mem_wdata_o);
    end
    tick();
    set_m(1, 1, 0, 8'd3, 0, 4'hF);
    tick();
    set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'h000000FF) begin
      bad++; $display("FAIL be_read: rvalid=%b rdata=%h, need 1 000000ff", m1_rvalid_o, m1_rdata_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_m(0, 1, 0, 8'd5, 0, 4'hF);
    @(negedge clk);
    total++;
    if (m0_gnt_o !== 1'b1 || mem_addr_o !== 8'd5) begin
      bad++; $display("FAIL b2b_gnt0: gnt0=%b addr=%h, need 1 05", m0_gnt_o, mem_addr_o);
    end
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 0, 8'd6, 0, 4'hF);
    @(negedge clk);
    total++;
    if (m1_gnt_o !== 1'b1 || m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h55555555 || m1_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL b2b_t1: gnt1=%b rvalid=%b%b rdata0=%h, need 1 10 55555555", m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
    end
    tick();
    set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'h66666666 || m0_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL b2b_t2: rvalid=%b%b rdata1=%h, need 01 66666666", m0_rvalid_o, m1_rvalid_o, m1_rdata_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_m(0, 1, 0, 8'd7, 0, 4'hF);
    @(negedge clk);
    total++;
    if (m0_gnt_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_gnt: gnt0=%b need 1", m0_gnt_o);
    end
    tick();
    rst_n = 0;
    set_m(0, 1, 0, 8'd1, 0, 4'hF);
    set_m(1, 1, 0, 8'd2, 0, 4'hF);
    @(negedge clk);
    total++;
    if (m0_rvalid_o !== 1'b0 || m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_hold: rvalid0=%b gnt=%b%b, need 0 00", m0_rvalid_o, m0_gnt_o, m1_gnt_o);
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0 || m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_after: gnt=%b%b rvalid=%b%b, need 10 00", m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o);
    end
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    logic g0 = 0, g1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!m0_req || g0 || $urandom_range(15) == 0)
        set_m(0, $urandom_range(3) != 0, 1'($urandom), 8'($urandom_range(15)), $urandom, 4'($urandom));
      if (!m1_req || g1 || $urandom_range(15) == 0)
        set_m(1, $urandom_range(3) != 0, 1'($urandom), 8'($urandom_range(15)), $urandom, 4'($urandom));
      @(negedge clk);
      total++;
      if ({m0_gnt_o, m1_gnt_o, mem_en_o} !== {e_g0, e_g1, e_any} ||
          {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== e_cmd) begin
        bad++; $display("FAIL rand_cmd[%0d]: gnt=%b%b cmd=%h, need %b%b %h", c, m0_gnt_o, m1_gnt_o,
                        {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, e_g0, e_g1, e_cmd);
      end
      total++;
      if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== {e_rv0, e_rv1, e_rd0, e_rd1}) begin
        bad++; $display("FAIL rand_rsp[%0d]: rvalid=%b%b rdata=%h/%h, need %b%b %h/%h", c, m0_rvalid_o, m1_rvalid_o,
                        m0_rdata_o, m1_rdata_o, e_rv0, e_rv1, e_rd0, e_rd1);
      end
      g0 = e_g0;
      g1 = e_g1;
      tick();
    end
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    set_m(0, 1, 0, 8'd0, 0, 4'hF);
    set_m(1, 1, 0, 8'd1, 0, 4'hF);
    for (int k = 0; k < 10; k++) tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (m0_stall_cnt_o !== 32'd5 || m1_stall_cnt_o !== 32'd5) begin
      bad++; $display("FAIL perf_cnt: stall=%0d/%0d, need 5/5", m0_stall_cnt_o, m1_stall_cnt_o);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_byte_enable();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
